pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 133 +++++++++++++
 tb/tb_pc_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program counter generator: BOOT/RUN/HALT sequencer, prioritised redirects, saturating fetch counter.
// Latency: next_pc is combinational; current_pc, state and fetch_count update on the next rising edge.
// Backpressure: with fetch_valid=1 and fetch_ready=0 the PC holds; only a redirect can move it.
module pc_gen #(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  PC_INC       = 1,
    parameter logic [PC_WIDTH-1:0] PC_RESET_VAL = '0,
    parameter int                  NUM_REDIR    = 2,   // legal range 1..8
    parameter int                  CNT_WIDTH    = 16,
    localparam int                 IDX_WIDTH    = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          halt_req,
    input  logic                          resume,
    input  logic [NUM_REDIR-1:0]          redir_valid,
    input  logic [NUM_REDIR*PC_WIDTH-1:0] redir_pc,
    input  logic                          fetch_ready,
    output logic                          fetch_valid,
    output logic [PC_WIDTH-1:0]           current_pc,
    output logic [PC_WIDTH-1:0]           next_pc,
    output logic                          redir_taken,
    output logic [IDX_WIDTH-1:0]          redir_idx,
    output logic                          halted,
    output logic [CNT_WIDTH-1:0]          fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                state;
    logic                  run_q;       // registered copy of (state == RUN)
    logic                  halted_q;    // registered copy of (state == HALT)
    logic [PC_WIDTH-1:0]   pc_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  fire;
    logic                  redir_any;
    logic [IDX_WIDTH-1:0]  redir_sel;
    logic [PC_WIDTH-1:0]   redir_target;

    // fetch_valid depends only on registered state and en, never on fetch_ready.
    assign fetch_valid = run_q & en;
    assign fire        = fetch_valid & fetch_ready;
    assign redir_any   = |redir_valid;

    // Lowest-index valid redirect channel wins; scanning downward lets lower indices overwrite.
    always_comb begin
        redir_sel    = '0;
        redir_target = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                redir_sel    = IDX_WIDTH'(i);
                redir_target = redir_pc[i*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    // Next PC priority: redirect, then increment on an accepted fetch, else hold.
    always_comb begin
        next_pc = pc_q;
        if (redir_any) begin
            next_pc = redir_target;
        end else if (fire) begin
            next_pc = pc_q + PC_WIDTH'(PC_INC);
        end
    end

    // Sequencer: transitions only while enabled; run/halted flags are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            run_q    <= 1'b0;
            halted_q <= 1'b0;
        end else if (en) begin
            case (state)
                BOOT: begin
                    state    <= RUN;
                    run_q    <= 1'b1;
                    halted_q <= 1'b0;
                end
                RUN: begin
                    if (halt_req) begin
                        state    <= HALT;
                        run_q    <= 1'b0;
                        halted_q <= 1'b1;
                    end
                end
                HALT: begin
                    // A still-asserted halt_req outranks resume.
                    if (resume && !halt_req) begin
                        state    <= RUN;
                        run_q    <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= BOOT;
                    run_q    <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // PC register follows next_pc every edge; redirects land in any state, even with en low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_RESET_VAL;
        end else begin
            pc_q <= next_pc;
        end
    end

    // Accepted fetches are counted even when a redirect overrides the increment; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (fire && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign current_pc  = pc_q;
    assign redir_taken = redir_any;
    assign redir_idx   = redir_sel;
    assign halted      = halted_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: default-parameter instance against a reference model, plus a narrow instance.
// Latency: one clock per step; outputs sampled 1 time unit after the rising edge.
// Backpressure: fetch_ready is driven directly, both held low and randomised.
module tb_pc_gen;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: default parameters ----------------
    logic        rst_n, en, halt_req, resume, fetch_ready;
    logic [1:0]  redir_valid;
    logic [63:0] redir_pc;
    logic        fetch_valid, redir_taken, halted;
    logic [31:0] current_pc, next_pc;
    logic [0:0]  redir_idx;
    logic [15:0] fetch_count;

    pc_gen dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .halt_req(halt_req), .resume(resume),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .current_pc(current_pc), .next_pc(next_pc),
        .redir_taken(redir_taken), .redir_idx(redir_idx), .halted(halted),
        .fetch_count(fetch_count)
    );

    // ---------------- instance B: 8-bit PC, step 4, 2-bit counter ----------------
    logic        rst_b_n, en_b, halt_b, resume_b, rdy_b;
    logic [1:0]  rv_b;
    logic [15:0] rpc_b;
    logic        fv_b, rt_b, halted_b;
    logic [7:0]  pc_b, npc_b;
    logic [0:0]  idx_b;
    logic [1:0]  cnt_b;

    pc_gen #(.PC_WIDTH(8), .PC_INC(4), .PC_RESET_VAL(8'h00), .NUM_REDIR(2), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .en(en_b), .halt_req(halt_b), .resume(resume_b),
        .redir_valid(rv_b), .redir_pc(rpc_b), .fetch_ready(rdy_b),
        .fetch_valid(fv_b), .current_pc(pc_b), .next_pc(npc_b),
        .redir_taken(rt_b), .redir_idx(idx_b), .halted(halted_b),
        .fetch_count(cnt_b)
    );

    // ---------------- reference model for instance A ----------------
    // mode: 0 = boot, 1 = run, 2 = halt
    int          m_mode;
    logic [31:0] m_pc;
    int          m_cnt;

    task automatic m_reset();
        m_mode = 0;
        m_pc   = 32'h0;
        m_cnt  = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of instance A: drive, check combinational outputs, clock, check state.
    task automatic step(input logic e, input logic h, input logic r, input logic [1:0] rv,
                        input logic [31:0] p0, input logic [31:0] p1, input logic rd);
        logic        offer, accept, won;
        int          widx;
        logic [31:0] target, expect_next;
        logic [31:0] pcs [2];
        en = e; halt_req = h; resume = r; redir_valid = rv; redir_pc = {p1, p0}; fetch_ready = rd;
        #1;
        pcs[0] = p0;
        pcs[1] = p1;
        offer  = (m_mode == 1) && e;
        accept = offer && rd;
        won    = 1'b0;
        widx   = 0;
        target = 32'h0;
        for (int i = 0; i < 2; i++) begin
            if (rv[i] && !won) begin
                won    = 1'b1;
                widx   = i;
                target = pcs[i];
            end
        end
        if (won)         expect_next = target;
        else if (accept) expect_next = m_pc + 32'd1;
        else             expect_next = m_pc;
        chk("fetch_valid_pre", {63'b0, fetch_valid}, {63'b0, offer});
        chk("next_pc", {32'b0, next_pc}, {32'b0, expect_next});
        chk("redir_taken", {63'b0, redir_taken}, {63'b0, won});
        chk("redir_idx", {63'b0, redir_idx}, 64'(widx));
        @(posedge clk);
        #1;
        m_pc = expect_next;
        if (accept && m_cnt < 65535) m_cnt++;
        if (e) begin
            if (m_mode == 0)                 m_mode = 1;
            else if (m_mode == 1 && h)       m_mode = 2;
            else if (m_mode == 2 && r && !h) m_mode = 1;
        end
        chk("current_pc", {32'b0, current_pc}, {32'b0, m_pc});
        chk("halted", {63'b0, halted}, {63'b0, (m_mode == 2)});
        chk("fetch_count", {48'b0, fetch_count}, 64'(m_cnt));
        chk("fetch_valid_post", {63'b0, fetch_valid}, {63'b0, ((m_mode == 1) && e)});
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; halt_req = 1'b0; resume = 1'b0;
        redir_valid = 2'b11; redir_pc = {32'h55, 32'h66}; fetch_ready = 1'b1;
        rst_b_n = 1'b0; en_b = 1'b0; halt_b = 1'b0; resume_b = 1'b0;
        rdy_b = 1'b0; rv_b = 2'b00; rpc_b = 16'h0;
        m_reset();

        // ---- instance B: wrap and saturation (A held in reset with redirects asserted) ----
        @(posedge clk); #1;
        rst_b_n = 1'b1;
        en_b = 1'b1;
        @(posedge clk); #1;
        chk("b_fetch_valid_run", {63'b0, fv_b}, 64'd1);
        rv_b = 2'b01; rpc_b = {8'h00, 8'hFC};
        @(posedge clk); #1;
        chk("b_pc_redir_fc", {56'b0, pc_b}, 64'hFC);
        chk("b_cnt_zero", {62'b0, cnt_b}, 64'd0);
        rv_b = 2'b00; rdy_b = 1'b1;
        #1;
        chk("b_next_pc_wrap", {56'b0, npc_b}, 64'h00);
        @(posedge clk); #1;
        chk("b_pc_wrap", {56'b0, pc_b}, 64'h00);
        chk("b_cnt_one", {62'b0, cnt_b}, 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("b_cnt_saturate", {62'b0, cnt_b}, 64'd3);
        chk("b_pc_after_5", {56'b0, pc_b}, 64'h10);
        rdy_b = 1'b0;

        // ---- instance A: state while held in reset ----
        chk("rst_pc", {32'b0, current_pc}, 64'h0);
        chk("rst_count", {48'b0, fetch_count}, 64'h0);
        chk("rst_fetch_valid", {63'b0, fetch_valid}, 64'd0);
        chk("rst_halted", {63'b0, halted}, 64'd0);
        redir_valid = 2'b00;
        rst_n = 1'b1;
        m_reset();

        // ---- boot then sequential fetches with backpressure at PC=5 ----
        step(1, 0, 0, 2'b00, 0, 0, 1);
        chk("boot_pc0", {32'b0, current_pc}, 64'h0);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 2'b00, 0, 0, 1);
        chk("pc_at_5", {32'b0, current_pc}, 64'h5);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 2'b00, 0, 0, 0);
        chk("bp_hold_5", {32'b0, current_pc}, 64'h5);
        chk("bp_valid", {63'b0, fetch_valid}, 64'd1);
        step(1, 0, 0, 2'b00, 0, 0, 1);
        chk("bp_step_6", {32'b0, current_pc}, 64'h6);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 2'b00, 0, 0, 1);
        chk("count_10", {48'b0, fetch_count}, 64'd10);
        chk("pc_10", {32'b0, current_pc}, 64'hA);

        // ---- redirect priority over a same-cycle fire ----
        step(1, 0, 0, 2'b01, 32'h7, 0, 0);
        step(1, 0, 0, 2'b11, 32'h40, 32'h80, 1);
        chk("prio_pc", {32'b0, current_pc}, 64'h40);
        chk("prio_count", {48'b0, fetch_count}, 64'd11);

        // ---- halt with fire, redirect while halted, resume ----
        step(1, 0, 0, 2'b01, 32'h3, 0, 0);
        step(1, 1, 0, 2'b00, 0, 0, 1);
        chk("halt_pc4", {32'b0, current_pc}, 64'h4);
        chk("halt_flag", {63'b0, halted}, 64'd1);
        step(1, 0, 0, 2'b10, 0, 32'h100, 1);
        chk("halt_redir_pc", {32'b0, current_pc}, 64'h100);
        step(1, 1, 1, 2'b00, 0, 0, 1);
        chk("resume_blocked", {63'b0, halted}, 64'd1);
        step(1, 0, 1, 2'b00, 0, 0, 1);
        step(1, 0, 0, 2'b00, 0, 0, 1);
        chk("resume_pc", {32'b0, current_pc}, 64'h101);

        // ---- redirect with en low, then randomised traffic ----
        step(0, 0, 0, 2'b10, 0, 32'hABCD, 1);
        chk("en_low_redir", {32'b0, current_pc}, 64'hABCD);
        for (int k = 0; k < 400; k++) begin
            logic [1:0] rv;
            rv[0] = ($urandom_range(0, 7) == 0);
            rv[1] = ($urandom_range(0, 7) == 0);
            step(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) == 0), rv, $urandom, $urandom,
                 ($urandom_range(0, 1) == 1));
        end

        // ---- asynchronous reset mid-cycle in RUN at PC=0x22 ----
        step(1, 0, 1, 2'b00, 0, 0, 0);
        step(1, 0, 1, 2'b00, 0, 0, 0);
        step(1, 0, 0, 2'b01, 32'h22, 0, 0);
        chk("pre_arst_pc", {32'b0, current_pc}, 64'h22);
        chk("pre_arst_valid", {63'b0, fetch_valid}, 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", {32'b0, current_pc}, 64'h0);
        chk("arst_valid", {63'b0, fetch_valid}, 64'd0);
        chk("arst_count", {48'b0, fetch_count}, 64'd0);
        redir_valid = 2'b01; redir_pc = {32'h0, 32'h77};
        @(posedge clk); #1;
        chk("arst_redir_ignored", {32'b0, current_pc}, 64'h0);
        redir_valid = 2'b00;
        rst_n = 1'b1;
        m_reset();
        step(1, 0, 0, 2'b00, 0, 0, 1);
        step(1, 0, 0, 2'b00, 0, 0, 1);
        chk("restart_pc1", {32'b0, current_pc}, 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
